census_cost_sequencer: RTL

- Front-end controller for the census Hamming-cost engine.
- Joins the independently timed left and right census streams into lock-step pairs, drives the engine's input/valid, and tracks column/row position.
- Delays frame metadata by the engine latency so it arrives aligned with the 64-wide cost vector.
- Produces a per-disparity validity mask so downstream WTA ignores costs whose right-image pixel lies left of column 0, or belongs to the previous row.

---
 rtl/census_cost_sequencer_pkg.sv | 30 +++
 rtl/census_cost_sequencer_if.sv | 38 +++
 rtl/census_cost_sequencer_skew.sv | 55 +++++
 rtl/census_cost_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/census_cost_sequencer_pkg.sv
// Shared types and default constants for the census cost front-end.
package census_pkg;

    localparam int MAX_DISP  = 64;
    localparam int CEN_W     = 25;
    localparam int COST_LAT  = 6;
    localparam int IMG_W_MAX = 640;
    localparam int IMG_H_MAX = 480;
    localparam int COL_W     = $clog2(IMG_W_MAX);
    localparam int ROW_W     = $clog2(IMG_H_MAX);

    typedef logic [CEN_W-1:0] census_t;

    // Position metadata that travels alongside each cost vector
    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic             sol;
        logic             eol;
        logic             sof;
        logic             eof;
    } cost_meta_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/census_cost_sequencer_if.sv
// Stream, engine and metadata signals of the census cost sequencer.
interface census_cost_sequencer_if #(
    parameter int COL_W    = census_pkg::COL_W,
    parameter int ROW_W    = census_pkg::ROW_W,
    parameter int MAX_DISP = census_pkg::MAX_DISP
);
    logic                 frame_start;
    census_pkg::census_t  in_L;
    logic                 in_L_valid;
    census_pkg::census_t  in_R;
    logic                 in_R_valid;
    logic                 err_clr;
    census_pkg::census_t  eng_L;
    census_pkg::census_t  eng_R;
    logic                 eng_valid;
    logic                 meta_valid;
    logic [MAX_DISP-1:0]  disp_mask;
    logic [COL_W-1:0]     out_col;
    logic [ROW_W-1:0]     out_row;
    logic                 out_sol;
    logic                 out_eol;
    logic                 out_sof;
    logic                 out_eof;
    logic                 busy;
    logic                 err_ovf;

    modport master (
        output frame_start, in_L, in_L_valid, in_R, in_R_valid, err_clr,
        input  eng_L, eng_R, eng_valid, meta_valid, disp_mask, out_col, out_row,
        input  out_sol, out_eol, out_sof, out_eof, busy, err_ovf
    );

    modport slave (
        input  frame_start, in_L, in_L_valid, in_R, in_R_valid, err_clr,
        output eng_L, eng_R, eng_valid, meta_valid, disp_mask, out_col, out_row,
        output out_sol, out_eol, out_sof, out_eof, busy, err_ovf
    );
endinterface

// File: rtl/census_cost_sequencer_skew.sv
// Single-clock skew FIFO absorbing the timing offset between census streams.
module skew_fifo #(
    parameter int DATA_W = 25,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic [AW-1:0]     wr_addr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A clear empties the FIFO first, so a word arriving alongside it always fits
    assign do_pop  = pop && !empty && !clr;
    assign do_push = push && (!full || do_pop || clr);
    assign wr_addr = clr ? '0 : wr_ptr[AW-1:0];
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_addr] <= din;
    end

    // Read/write pointer update, with clear restarting both at slot 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= (AW+1)'(do_push);
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/census_cost_sequencer.sv
// Pairs left/right census words, feeds the Hamming-cost engine and delays
// position metadata and the disparity validity mask to line up with its output.
module census_cost_sequencer #(
    parameter int MAX_DISP   = census_pkg::MAX_DISP,
    parameter int CEN_W      = census_pkg::CEN_W,
    parameter int IMG_W      = census_pkg::IMG_W_MAX,
    parameter int IMG_H      = census_pkg::IMG_H_MAX,
    parameter int SKEW_DEPTH = 4,
    parameter int COST_LAT   = census_pkg::COST_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    census_cost_sequencer_if.slave   bus
);
    import census_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    seq_state_t          state, state_nxt;
    logic                push_l, push_r, pop;
    logic                full_l, full_r, empty_l, empty_r;
    logic                ovf;
    logic                last_pair;
    logic [CEN_W-1:0]    dout_l, dout_r;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;

    logic                vld_p0;
    logic [CEN_W-1:0]    eng_l_p0, eng_r_p0;
    logic [CW-1:0]       col_p0;
    logic [RW-1:0]       row_p0;

    logic [COST_LAT-1:0] vld_p1;
    cost_meta_t          meta_p1 [COST_LAT];
    logic [MAX_DISP-1:0] mask_p1 [COST_LAT];
    cost_meta_t          meta_o;

    function automatic logic [MAX_DISP-1:0] disp_mask_f(input logic [CW-1:0] c);
        logic [MAX_DISP-1:0] m;
        for (int d = 0; d < MAX_DISP; d++)
            m[d] = (int'(c) >= d);
        return m;
    endfunction

    function automatic cost_meta_t meta_of(input logic [CW-1:0] c, input logic [RW-1:0] r);
        cost_meta_t m;
        m.col = COL_W'(c);
        m.row = ROW_W'(r);
        m.sol = (c == '0);
        m.eol = (c == CW'(IMG_W-1));
        m.sof = (c == '0) && (r == '0);
        m.eof = (c == CW'(IMG_W-1)) && (r == RW'(IMG_H-1));
        return m;
    endfunction

    skew_fifo #(.DATA_W(CEN_W), .DEPTH(SKEW_DEPTH)) u_fifo_l (
        .clk(clk), .rst_n(rst_n), .clr(bus.frame_start), .push(push_l), .pop(pop),
        .din(bus.in_L), .dout(dout_l), .full(full_l), .empty(empty_l)
    );

    skew_fifo #(.DATA_W(CEN_W), .DEPTH(SKEW_DEPTH)) u_fifo_r (
        .clk(clk), .rst_n(rst_n), .clr(bus.frame_start), .push(push_r), .pop(pop),
        .din(bus.in_R), .dout(dout_r), .full(full_r), .empty(empty_r)
    );

    assign last_pair = (col == CW'(IMG_W-1)) && (row == RW'(IMG_H-1));
    // A pushed word is lost only if its FIFO stays full through this edge
    assign ovf = !bus.frame_start &&
                 ((push_l && full_l && !pop) || (push_r && full_r && !pop));

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus FIFO push/pop gating (strobes outside a frame are dropped)
    always_comb begin
        state_nxt = state;
        push_l    = 1'b0;
        push_r    = 1'b0;
        pop       = 1'b0;
        if (state == ST_RUN || bus.frame_start) begin
            push_l = bus.in_L_valid;
            push_r = bus.in_R_valid;
        end
        if (state == ST_RUN && !bus.frame_start)
            pop = !empty_l && !empty_r;
        case (state)
            ST_IDLE: if (bus.frame_start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.frame_start)
                    state_nxt = ST_RUN;
                else if (pop && last_pair)
                    state_nxt = ST_DONE;
            end
            ST_DONE: if (bus.frame_start) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Column/row of the next pair to issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (bus.frame_start) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (col == CW'(IMG_W-1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Sticky overflow flag; a new overflow wins over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.err_ovf <= 1'b0;
        else if (ovf)
            bus.err_ovf <= 1'b1;
        else if (bus.err_clr)
            bus.err_ovf <= 1'b0;
    end

    // ---- p0: engine issue register ----
    // Issued pair and strobe; data holds between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            eng_l_p0 <= '0;
            eng_r_p0 <= '0;
        end else begin
            vld_p0 <= pop;
            if (pop) begin
                eng_l_p0 <= dout_l;
                eng_r_p0 <= dout_r;
            end
        end
    end

    // Position of the issued pair, captured with it
    always_ff @(posedge clk) begin
        if (pop) begin
            col_p0 <= col;
            row_p0 <= row;
        end
    end

    // ---- p1: metadata delay line matching engine latency ----
    // Valid bits shift every cycle so meta_valid is eng_valid delayed exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= '0;
        else
            vld_p1 <= {vld_p1[COST_LAT-2:0], vld_p0};
    end

    // Metadata and mask payload, gated at the output by its valid bit
    always_ff @(posedge clk) begin
        meta_p1[0] <= meta_of(col_p0, row_p0);
        mask_p1[0] <= disp_mask_f(col_p0);
        for (int k = 1; k < COST_LAT; k++) begin
            meta_p1[k] <= meta_p1[k-1];
            mask_p1[k] <= mask_p1[k-1];
        end
    end

    assign meta_o         = meta_p1[COST_LAT-1];
    assign bus.eng_L      = eng_l_p0;
    assign bus.eng_R      = eng_r_p0;
    assign bus.eng_valid  = vld_p0;
    assign bus.meta_valid = vld_p1[COST_LAT-1];
    assign bus.disp_mask  = bus.meta_valid ? mask_p1[COST_LAT-1] : '0;
    assign bus.out_col    = bus.meta_valid ? CW'(meta_o.col) : '0;
    assign bus.out_row    = bus.meta_valid ? RW'(meta_o.row) : '0;
    assign bus.out_sol    = bus.meta_valid && meta_o.sol;
    assign bus.out_eol    = bus.meta_valid && meta_o.eol;
    assign bus.out_sof    = bus.meta_valid && meta_o.sof;
    assign bus.out_eof    = bus.meta_valid && meta_o.eof;
    assign bus.busy       = (state == ST_RUN) || vld_p0 || (|vld_p1);

endmodule
